async_fifo_rd_ctrl: RTL and testbench

Read-domain controller for the async FIFO.
- Owns the read pointer, both binary and Gray forms, and the SRAM read address.
- Synchronises the raw Gray write pointer into clk_r internally; no external synchroniser is needed.
- Generates registered empty, almost_empty, fill-level and underflow status.
- Generalises the earlier fixed 3-bit read pointer logic to any depth, with a configurable synchroniser depth and threshold.

---
 rtl/async_fifo_pkg.sv | 31 +++
 rtl/gray_ptr_sync.sv | 34 +++
 rtl/async_fifo_rd_ctrl.sv | 100 ++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for both async FIFO controllers.
package async_fifo_pkg;

    localparam int DEF_ADDR_W      = 3;
    localparam int DEF_SYNC_STAGES = 2;
    // Widest pointer the helpers handle; callers zero-extend into this width.
    localparam int MAX_PTR_W       = 16;

    // Binary to reflected Gray: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        logic [MAX_PTR_W-1:0] g;
        g = '0;
        for (int i = 0; i < MAX_PTR_W - 1; i++) begin
            g[i] = b[i] ^ b[i+1];
        end
        g[MAX_PTR_W-1] = b[MAX_PTR_W-1];
        return g;
    endfunction

    // Gray to binary: running XOR from the MSB downwards.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b = '0;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Only one bit changes per pointer step, so a metastable capture resolves to
// either the old or the new pointer value, never a mix.
module gray_ptr_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2    // legal range 2..4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_chain [STAGES];

    // Shift the asynchronous pointer through the chain; every stage clears on reset.
    // NOTE: the chain is a handful of flops, not a RAM, so resetting each entry is cheap
    // and keeps a stale pointer from leaking out of a reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO: read pointer (binary and Gray),
// SRAM read address, write-pointer synchroniser and registered status flags.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,       // 1..MAX_PTR_W-2
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,  // 2..4
    parameter int AEMPTY_THRESH = 1                 // 0..2**ADDR_W-1
) (
    input  logic              clk_r,
    input  logic              arst,
    input  logic              r_en,
    input  logic [ADDR_W:0]   g_wptr_async,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W:0]   b_rptr,
    output logic [ADDR_W:0]   g_rptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);

    localparam int                PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  AE_TH = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0]     r_b_rptr;
    logic [PTR_W-1:0]     r_g_rptr;
    logic                 r_empty;
    logic                 r_almost_empty;
    logic [PTR_W-1:0]     r_rd_level;
    logic                 r_underflow;

    logic [PTR_W-1:0]     w_g_wptr_sync;
    logic [MAX_PTR_W-1:0] w_wbin_full;
    logic [PTR_W-1:0]     w_wbin_sync;
    logic                 w_rd_ok;
    logic [PTR_W-1:0]     w_b_rptr_next;
    logic [MAX_PTR_W-1:0] w_g_full;
    logic [PTR_W-1:0]     w_g_rptr_next;
    logic [PTR_W-1:0]     w_lvl_next;
    logic                 w_unused_hi;

    gray_ptr_sync #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk  (clk_r),
        .arst (arst),
        .i_d  (g_wptr_async),
        .o_q  (w_g_wptr_sync)
    );

    // A read is accepted only when the registered empty flag says data is present.
    assign w_rd_ok       = r_en & ~r_empty;
    assign w_b_rptr_next = r_b_rptr + PTR_W'(w_rd_ok);

    assign w_g_full      = bin2gray(MAX_PTR_W'(w_b_rptr_next));
    assign w_g_rptr_next = w_g_full[PTR_W-1:0];

    assign w_wbin_full   = gray2bin(MAX_PTR_W'(w_g_wptr_sync));
    assign w_wbin_sync   = w_wbin_full[PTR_W-1:0];

    // Modular subtraction stays correct across the pointer MSB wrap. The write
    // pointer is seen late, so the level can only under-report occupancy.
    assign w_lvl_next    = w_wbin_sync - w_b_rptr_next;

    // Upper bits of the helper results are zero by construction.
    assign w_unused_hi   = |{w_g_full[MAX_PTR_W-1:PTR_W], w_wbin_full[MAX_PTR_W-1:PTR_W]};

    // Advance the pointers and register status from the next-state pointer, so a
    // read of the last word raises empty on the same edge that moves the pointer.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values,
    // regardless of the order the statements are written in.
    always_ff @(posedge clk_r or posedge arst) begin
        if (arst) begin
            r_b_rptr       <= '0;
            r_g_rptr       <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_level     <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_b_rptr       <= w_b_rptr_next;
            r_g_rptr       <= w_g_rptr_next;
            r_empty        <= (w_g_rptr_next == w_g_wptr_sync);
            r_almost_empty <= (w_lvl_next <= AE_TH);
            r_rd_level     <= w_lvl_next;
            r_underflow    <= r_en & r_empty;
        end
    end

    assign r_addr       = r_b_rptr[ADDR_W-1:0];
    assign b_rptr       = r_b_rptr;
    assign g_rptr       = r_g_rptr;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_level     = r_rd_level;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl with ADDR_W=3, SYNC_STAGES=2, AEMPTY_THRESH=1.
module tb_async_fifo_rd_ctrl;

    localparam int ADDR_W = 3;

    logic          clk_r = 1'b0;
    logic          arst;
    logic          r_en;
    logic [ADDR_W:0]   g_wptr_async;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   b_rptr;
    logic [ADDR_W:0]   g_rptr;
    logic          empty;
    logic          almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    async_fifo_rd_ctrl #(
        .ADDR_W        (ADDR_W),
        .SYNC_STAGES   (2),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk_r        (clk_r),
        .arst         (arst),
        .r_en         (r_en),
        .g_wptr_async (g_wptr_async),
        .r_addr       (r_addr),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    always #5 clk_r = ~clk_r;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against a hand-derived expected state.
    task automatic check_state(input string tag, input int b, input int lvl,
                               input bit e, input bit ae, input bit uf);
        check({tag, ".b_rptr"},       32'(b_rptr),       32'(b & 15));
        check({tag, ".r_addr"},       32'(r_addr),       32'(b & 7));
        check({tag, ".g_rptr"},       32'(g_rptr),       32'(gray(b)));
        check({tag, ".rd_level"},     32'(rd_level),     32'(lvl));
        check({tag, ".empty"},        32'(empty),        32'(e));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        check({tag, ".underflow"},    32'(underflow),    32'(uf));
    endtask

    task automatic tick();
        @(posedge clk_r);
        #1;
    endtask

    logic [3:0] prev_g;
    int         eb;

    initial begin
        // ---- reset ----
        arst = 1'b1;
        r_en = 1'b0;
        g_wptr_async = '0;
        #1;
        check_state("reset_t0", 0, 0, 1, 1, 0);
        tick();
        tick();
        check_state("reset_held", 0, 0, 1, 1, 0);
        arst = 1'b0;
        tick();
        check_state("idle", 0, 0, 1, 1, 0);

        // ---- sync latency: 0 -> 1 becomes visible at edge k+2 ----
        g_wptr_async = gray(1);
        tick();
        check_state("lat_k", 0, 0, 1, 1, 0);
        tick();
        check_state("lat_k1", 0, 0, 1, 1, 0);
        tick();
        check_state("lat_k2", 0, 1, 0, 1, 0);

        // ---- drain four words ----
        g_wptr_async = gray(4);
        tick();
        tick();
        check_state("fill4_pre", 0, 1, 0, 1, 0);
        tick();
        check_state("fill4", 0, 4, 0, 0, 0);
        r_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_state($sformatf("drain%0d", i), i, 4 - i, (i == 4), ((4 - i) <= 1), 0);
        end

        // ---- underflow: r_en stays high while empty ----
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_state($sformatf("uflow%0d", i), 4, 0, 1, 1, 1);
        end
        r_en = 1'b0;
        tick();
        check_state("uflow_end", 4, 0, 1, 1, 0);

        // ---- wrap phase A: write pointer at 12, read 8 (crosses 7->8) ----
        g_wptr_async = gray(12);
        tick();
        tick();
        tick();
        check_state("wrapA_fill", 4, 8, 0, 0, 0);
        prev_g = g_rptr;
        r_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_state($sformatf("wrapA%0d", i), 4 + i, 8 - i, (i == 8), ((8 - i) <= 1), 0);
            check($sformatf("wrapA%0d.gray_step", i), 32'($countones(g_rptr ^ prev_g)), 32'd1);
            prev_g = g_rptr;
        end
        r_en = 1'b0;

        // ---- wrap phase B: write pointer at 16 (=0), read 4 (crosses 15->0) ----
        g_wptr_async = gray(0);
        tick();
        tick();
        check_state("wrapB_pre", 12, 0, 1, 1, 0);
        tick();
        check_state("wrapB_fill", 12, 4, 0, 0, 0);
        r_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_state($sformatf("wrapB%0d", i), (12 + i) % 16, 4 - i, (i == 4), ((4 - i) <= 1), 0);
            check($sformatf("wrapB%0d.gray_step", i), 32'($countones(g_rptr ^ prev_g)), 32'd1);
            prev_g = g_rptr;
        end
        r_en = 1'b0;

        // ---- full FIFO is not empty: wptr=8, rptr=0 ----
        g_wptr_async = gray(8);
        tick();
        tick();
        tick();
        check_state("full", 0, 8, 0, 0, 0);

        // ---- simultaneous read and synced write at level 1 ----
        r_en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_state($sformatf("to_lvl1_%0d", i), i, 8 - i, 0, ((8 - i) <= 1), 0);
        end
        r_en = 1'b0;
        g_wptr_async = gray(9);
        tick();
        check_state("simul_k", 7, 1, 0, 1, 0);
        tick();
        check_state("simul_k1", 7, 1, 0, 1, 0);
        r_en = 1'b1;
        tick();
        check_state("simul_k2", 8, 1, 0, 1, 0);
        r_en = 1'b0;

        // ---- bring b_rptr to 5 (via 16), then reset mid-cycle ----
        g_wptr_async = gray(16);
        tick();
        tick();
        tick();
        check_state("pre_rst_fill", 8, 8, 0, 0, 0);
        r_en = 1'b1;
        repeat (8) tick();
        r_en = 1'b0;
        check_state("pre_rst_drained", 0, 0, 1, 1, 0);
        g_wptr_async = gray(6);
        tick();
        tick();
        tick();
        check_state("pre_rst_fill6", 0, 6, 0, 0, 0);
        r_en = 1'b1;
        eb = 0;
        repeat (5) begin
            tick();
            eb++;
        end
        r_en = 1'b0;
        check_state("pre_rst_b5", eb, 1, 0, 1, 0);
        #2;
        arst = 1'b1;
        #1;
        check_state("reset_mid", 0, 0, 1, 1, 0);
        tick();
        tick();
        arst = 1'b0;
        tick();
        check_state("post_rst_e1", 0, 0, 1, 1, 0);
        tick();
        tick();
        check_state("post_rst_e3", 0, 6, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
